// File: rtl/periodic_sample_scheduler_pkg.sv
// Shared constants for the periodic sample scheduler: record layout and phase width.
// A record is {timestamp, group}, with the group in the low bits.
package sample_sched_defs;

    localparam int PH_W = 16;

    function automatic int rec_w(input int ts_w, input int num_sig);
        return ts_w + num_sig;
    endfunction

    function automatic int grp_lsb();
        return 0;
    endfunction

    function automatic int ts_lsb(input int num_sig);
        return num_sig;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through record FIFO; the head entry is visible combinationally.
// A push into a full FIFO is only taken when a pop frees a slot on the same edge.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Entries are cleared on reset so nothing unknown can ever reach the head.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/periodic_sample_scheduler.sv
// Samples a signal group every PERIOD enabled cycles with a free-running timestamp,
// buffers the records and drains them over valid/ready; lost records are counted.
module periodic_sample_scheduler
    import sample_sched_defs::*;
#(
    parameter int NUM_SIG = 3,
    parameter int PERIOD  = 15,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 4,
    parameter int DROP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_SIG-1:0] sig,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [TS_W-1:0]    rec_ts,
    output logic [NUM_SIG-1:0] rec_group,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic               busy
);

    localparam int REC_W  = rec_w(TS_W, NUM_SIG);
    localparam int TS_LSB = ts_lsb(NUM_SIG);
    localparam int GR_LSB = grp_lsb();
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

    logic [TS_W-1:0]        time_cnt_reg;
    logic [PH_W-1:0]        phase_reg;
    logic [DROP_W-1:0]      drop_cnt_reg;
    logic                   tick;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [REC_W-1:0]       wr_rec;
    logic [REC_W-1:0]       head_rec;

    assign tick   = en && (phase_reg == PH_LAST);
    assign pop    = rec_ready && !fifo_empty;
    assign push   = tick && (!fifo_full || pop);
    assign drop   = tick && fifo_full && !pop;
    assign wr_rec = {time_cnt_reg, sig};

    always_ff @(posedge clk) begin
        if (rst) begin
            time_cnt_reg <= '0;
            phase_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            time_cnt_reg <= time_cnt_reg + 1'b1;
            // Dropping en abandons the partial period; re-enabling starts a full one.
            if (!en || tick) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
            if (drop && (drop_cnt_reg != {DROP_W{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_rec),
        .rd_data (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rec_valid = (fifo_count != '0);
    assign rec_ts    = head_rec[TS_LSB +: TS_W];
    assign rec_group = head_rec[GR_LSB +: NUM_SIG];
    assign drop_cnt  = drop_cnt_reg;
    assign busy      = en || rec_valid;

endmodule

// File: tb/tb_periodic_sample_scheduler.sv
// Scoreboard bench: directed stimulus queues expected records, monitors pop and compare.
// Two instances cover PERIOD=15 and PERIOD=1.
module tb_periodic_sample_scheduler;

    typedef struct {
        logic [31:0] ts;
        logic [2:0]  grp;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, en1 = 1'b0;
    logic [2:0]  sig = '0, sig1 = '0;
    logic        rec_ready = 1'b0, rec_ready1 = 1'b0;
    logic        rec_valid, rec_valid1;
    logic [31:0] rec_ts, rec_ts1;
    logic [2:0]  rec_group, rec_group1;
    logic [7:0]  drop_cnt, drop_cnt1;
    logic        busy, busy1;

    rec_t q0[$];
    rec_t q1[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    periodic_sample_scheduler #(
        .NUM_SIG(3), .PERIOD(15), .TS_W(32), .DEPTH(4), .DROP_W(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sig(sig),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
        .rec_group(rec_group), .drop_cnt(drop_cnt), .busy(busy)
    );

    periodic_sample_scheduler #(
        .NUM_SIG(3), .PERIOD(1), .TS_W(32), .DEPTH(4), .DROP_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en1), .sig(sig1),
        .rec_valid(rec_valid1), .rec_ready(rec_ready1), .rec_ts(rec_ts1),
        .rec_group(rec_group1), .drop_cnt(drop_cnt1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push0(input logic [31:0] ts, input logic [2:0] grp);
        rec_t r;
        r.ts = ts; r.grp = grp;
        q0.push_back(r);
    endtask

    task automatic push1(input logic [31:0] ts, input logic [2:0] grp);
        rec_t r;
        r.ts = ts; r.grp = grp;
        q1.push_back(r);
    endtask

    // Reset is applied for one edge; the next rising edge is edge 0 (time_cnt=0).
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; en1 = 1'b0; rec_ready = 1'b0; rec_ready1 = 1'b0;
        q0.delete(); q1.delete();
        step(1);
        rst = 1'b0;
    endtask

    // Monitors: inputs settle at negedge, so valid&ready seen 2 units later is a pop at the next edge.
    initial forever begin
        @(negedge clk); #2;
        if (!rst && rec_valid && rec_ready) begin
            if (q0.size() == 0) begin
                chk("unexpected_rec0", {rec_ts, rec_group}, 64'hDEAD);
            end else begin
                rec_t e;
                e = q0.pop_front();
                chk("rec0", {rec_ts, rec_group}, {e.ts, e.grp});
                $display("rec0 ts=%0d grp=%b (exp ts=%0d grp=%b)", rec_ts, rec_group, e.ts, e.grp);
            end
        end
    end

    initial forever begin
        @(negedge clk); #2;
        if (!rst && rec_valid1 && rec_ready1) begin
            if (q1.size() == 0) begin
                chk("unexpected_rec1", {rec_ts1, rec_group1}, 64'hDEAD);
            end else begin
                rec_t e;
                e = q1.pop_front();
                chk("rec1", {rec_ts1, rec_group1}, {e.ts, e.grp});
                $display("rec1 ts=%0d grp=%b (exp ts=%0d grp=%b)", rec_ts1, rec_group1, e.ts, e.grp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        do_reset();
        chk("rst_valid", rec_valid, 1'b0);
        chk("rst_ts", rec_ts, 32'd0);
        chk("rst_group", rec_group, 3'd0);
        chk("rst_drop", drop_cnt, 8'd0);
        chk("rst_busy", busy, 1'b0);

        // Basic periodic capture: ticks at edges 14 and 29
        en = 1'b1; sig = 3'b101; rec_ready = 1'b1;
        push0(32'd14, 3'b101);
        push0(32'd29, 3'b101);
        step(14);
        chk("pre_tick_valid", rec_valid, 1'b0);
        chk("busy_en", busy, 1'b1);
        step(1);
        chk("t1_valid", rec_valid, 1'b1);
        chk("t1_ts", rec_ts, 32'd14);
        step(1);
        chk("t1_pulse", rec_valid, 1'b0);
        step(14);
        chk("t2_ts", rec_ts, 32'd29);
        en = 1'b0;
        step(2);

        // PERIOD=1: six consecutive records ts 0..5
        do_reset();
        en1 = 1'b1; rec_ready1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sig1 = 3'(i);
            push1(32'(i), 3'(i));
            step(1);
        end
        en1 = 1'b0;
        step(2);
        chk("p1_drop", drop_cnt1, 8'd0);
        chk("p1_empty", rec_valid1, 1'b0);

        // Stalled sink for six periods: four kept, two dropped
        do_reset();
        en = 1'b1; rec_ready = 1'b0;
        push0(32'd14, 3'd1);
        push0(32'd29, 3'd2);
        push0(32'd44, 3'd3);
        push0(32'd59, 3'd4);
        push0(32'd104, 3'd7);
        for (int p = 0; p < 6; p++) begin
            sig = 3'(p + 1);
            step(15);
        end
        chk("full_drop", drop_cnt, 8'd2);
        chk("full_head", rec_ts, 32'd14);
        chk("full_group", rec_group, 3'd1);

        // Full buffer, pop and tick on edge 104: accepted, no extra drop
        sig = 3'd7;
        step(14);
        rec_ready = 1'b1;
        step(1);
        chk("pp_drop", drop_cnt, 8'd2);
        chk("pp_head", rec_ts, 32'd29);
        en = 1'b0;
        chk("busy_drain", busy, 1'b1);
        step(4);
        chk("pp_empty", rec_valid, 1'b0);
        chk("empty_ts", rec_ts, 32'd0);
        chk("empty_group", rec_group, 3'd0);
        chk("idle_busy", busy, 1'b0);

        // en dropped at phase 10 for 3 cycles
        do_reset();
        en = 1'b1; rec_ready = 1'b1; sig = 3'b110;
        push0(32'd27, 3'b110);
        step(10);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(2);
        chk("no_old_slot", rec_valid, 1'b0);
        step(13);
        chk("restart_valid", rec_valid, 1'b1);
        chk("restart_ts", rec_ts, 32'd27);
        en = 1'b0;
        step(2);

        // Reset with three records pending
        do_reset();
        en = 1'b1; rec_ready = 1'b0; sig = 3'b010;
        step(45);
        chk("pend_valid", rec_valid, 1'b1);
        chk("pend_head", rec_ts, 32'd14);
        rst = 1'b1; en = 1'b0;
        q0.delete();
        step(1);
        chk("mid_rst_valid", rec_valid, 1'b0);
        chk("mid_rst_drop", drop_cnt, 8'd0);
        chk("mid_rst_ts", rec_ts, 32'd0);
        rst = 1'b0;
        en = 1'b1; rec_ready = 1'b1;
        push0(32'd14, 3'b010);
        step(15);
        chk("restart_time", rec_ts, 32'd14);
        en = 1'b0;
        step(2);

        // 300 drops on PERIOD=1 instance saturate at 255
        do_reset();
        en1 = 1'b1; rec_ready1 = 1'b0; sig1 = 3'b100;
        step(104);
        chk("drop_100", drop_cnt1, 8'd100);
        step(200);
        chk("drop_sat", drop_cnt1, 8'd255);
        for (int i = 0; i < 4; i++) push1(32'(i), 3'b100);
        en1 = 1'b0; rec_ready1 = 1'b1;
        step(5);
        chk("sat_empty", rec_valid1, 1'b0);
        chk("sat_hold", drop_cnt1, 8'd255);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
